// File: rtl/venc1_crc_attach.sv
// Serial CRC generator for the venc1 transmit chain: forwards payload bits and
// appends the selected CRC (8/12/16/24) MSB-first behind a single output register.
module venc1_crc_attach (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] crc_sel,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [0:0] ST_DATA = 1'b0;
    localparam logic [0:0] ST_CRC  = 1'b1;

    logic [0:0]  state;
    logic [23:0] crc_reg;
    logic [4:0]  crc_cnt;
    logic [1:0]  sel_q;

    logic        adv;
    logic        xfer;
    logic        last_acc;
    logic        frame_first;
    logic [1:0]  sel_eff;

    function automatic logic [4:0] crc_len(input logic [1:0] sel);
        case (sel)
            2'b00:   crc_len = 5'd8;
            2'b01:   crc_len = 5'd12;
            2'b10:   crc_len = 5'd16;
            default: crc_len = 5'd24;
        endcase
    endfunction

    // Generator polynomial without the implicit D^L term.
    function automatic logic [23:0] crc_poly(input logic [1:0] sel);
        case (sel)
            2'b00:   crc_poly = 24'h00009B;
            2'b01:   crc_poly = 24'h00080F;
            2'b10:   crc_poly = 24'h001021;
            default: crc_poly = 24'h800063;
        endcase
    endfunction

    function automatic logic [23:0] crc_mask(input logic [1:0] sel);
        case (sel)
            2'b00:   crc_mask = 24'h0000FF;
            2'b01:   crc_mask = 24'h000FFF;
            2'b10:   crc_mask = 24'h00FFFF;
            default: crc_mask = 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic crc_msb(input logic [23:0] c, input logic [1:0] sel);
        case (sel)
            2'b00:   crc_msb = c[7];
            2'b01:   crc_msb = c[11];
            2'b10:   crc_msb = c[15];
            default: crc_msb = c[23];
        endcase
    endfunction

    function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b,
                                             input logic [1:0] sel);
        logic fb;
        fb = b ^ crc_msb(c, sel);
        crc_step = ({c[22:0], 1'b0} ^ (fb ? crc_poly(sel) : 24'd0)) & crc_mask(sel);
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = (state == ST_DATA) && adv;
    assign xfer     = in_valid && in_ready;
    assign last_acc = out_valid && out_ready && out_last;

    // A new frame may start in the very cycle the previous out_last is accepted,
    // while busy is still high.
    assign frame_first = !busy || last_acc;
    assign sel_eff     = frame_first ? crc_sel : sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_DATA;
            crc_reg   <= 24'd0;
            crc_cnt   <= 5'd0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            sel_q     <= 2'b00;
        end else if (adv) begin
            if (state == ST_DATA) begin
                if (xfer) begin
                    out_bit   <= in_bit;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    busy      <= 1'b1;
                    crc_reg   <= crc_step(crc_reg, in_bit, sel_eff);
                    if (frame_first) begin
                        sel_q <= crc_sel;
                    end
                    if (in_last) begin
                        state   <= ST_CRC;
                        crc_cnt <= crc_len(sel_eff) - 5'd1;
                    end
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (last_acc) begin
                        busy <= 1'b0;
                    end
                end
            end else begin
                out_bit   <= crc_msb(crc_reg, sel_q);
                out_valid <= 1'b1;
                out_last  <= (crc_cnt == 5'd0);
                crc_cnt   <= crc_cnt - 5'd1;
                if (crc_cnt == 5'd0) begin
                    state   <= ST_DATA;
                    crc_reg <= 24'd0;
                end else begin
                    crc_reg <= {crc_reg[22:0], 1'b0} & crc_mask(sel_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_venc1_crc_attach.sv
// Scoreboard bench for venc1_crc_attach: expected bits come from a polynomial
// long-division model and every codeword is re-divided to a zero remainder.
module tb_venc1_crc_attach;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] crc_sel;
    logic       in_valid;
    logic       in_bit;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    venc1_crc_attach dut (
        .clk       (clk),
        .rst       (rst),
        .crc_sel   (crc_sel),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          nout     = 0;
    int          bubbles  = 0;
    logic        stall_en = 1'b0;
    logic        frame_new = 1'b1;
    logic [1:0]  cur_sel;
    logic        cur[$];
    logic [1:0]  sb[$];
    logic        rx[$];
    logic [1:0]  rx_sel[$];
    logic [23:0] crc_hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int len_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 8;
            2'b01:   return 12;
            2'b10:   return 16;
            default: return 24;
        endcase
    endfunction

    // Remainder of the bit sequence divided by the full generator G(D).
    function automatic logic [23:0] div_rem(input logic q[$], input logic [1:0] sel);
        logic [24:0] r;
        logic [24:0] g;
        int          L;
        L = len_of(sel);
        case (sel)
            2'b00:   g = 25'h000009B;
            2'b01:   g = 25'h000080F;
            2'b10:   g = 25'h0001021;
            default: g = 25'h0800063;
        endcase
        g = g | (25'd1 << L);
        r = '0;
        foreach (q[i]) begin
            r = {r[23:0], q[i]};
            if (r[L]) r = r ^ g;
        end
        return r[23:0];
    endfunction

    task automatic send_bit(input logic b, input logic last, input logic [1:0] sel,
                            output int waits);
        logic        tmp[$];
        logic [23:0] rem;
        int          L;
        waits    = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        crc_sel  = sel;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 2000) begin
                chk("in_ready_timeout", 32'(waits), 0);
                break;
            end
        end
        if (frame_new) begin
            cur_sel   = sel;
            frame_new = 1'b0;
            cur.delete();
        end
        cur.push_back(b);
        sb.push_back({b, 1'b0});
        if (last) begin
            L   = len_of(cur_sel);
            tmp = cur;
            for (int i = 0; i < L; i++) tmp.push_back(1'b0);
            rem = div_rem(tmp, cur_sel);
            for (int i = L - 1; i >= 0; i--) sb.push_back({rem[i], (i == 0)});
            rx_sel.push_back(cur_sel);
            frame_new = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // pat: 0 all zeros, 1 all ones, 2 random; toggle scrambles crc_sel after bit 0.
    task automatic send_frame(input logic [1:0] sel, input int n, input int pat,
                              input logic toggle);
        logic b;
        logic [1:0] s;
        int w;
        for (int i = 0; i < n; i++) begin
            b = (pat == 0) ? 1'b0 : (pat == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            s = (toggle && i > 0) ? 2'($urandom_range(0, 3)) : sel;
            send_bit(b, (i == n - 1), s, w);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) chk(tag, 32'(sb.size()), 0);
    endtask

    // Output monitor: a transfer seen at the negedge commits on the next posedge.
    always @(negedge clk) begin
        logic [1:0]  e;
        logic [1:0]  s;
        logic [23:0] word;
        int          L;
        if (!rst && busy && !out_valid) bubbles++;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_bit", 32'(out_bit), 32'(e[1]));
                chk("out_last", 32'(out_last), 32'(e[0]));
            end
            rx.push_back(out_bit);
            nout++;
            if (out_last) begin
                s    = (rx_sel.size() != 0) ? rx_sel.pop_front() : 2'b00;
                L    = len_of(s);
                word = '0;
                for (int i = rx.size() - L; i < rx.size(); i++) word = {word[22:0], rx[i]};
                crc_hist.push_back(word);
                chk("rx_remainder", 32'(div_rem(rx, s)), 0);
                rx.delete();
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        crc_sel  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: CRC8 on a single 1 bit
        crc_hist.delete();
        n0 = nout;
        send_frame(2'b00, 1, 1, 1'b0);
        drain("t1_drain");
        chk("t1_nout", 32'(nout - n0), 9);
        chk("t1_crc", (crc_hist.size() > 0) ? 32'(crc_hist[$]) : 32'hDEAD, 32'h9B);

        // 2: CRC16 then CRC24, back-to-back
        crc_hist.delete();
        bubbles = 0;
        send_bit(1'b1, 1'b1, 2'b10, w);
        send_bit(1'b1, 1'b1, 2'b11, w);
        chk("t2_wait", 32'(w), 16);
        drain("t2_drain");
        chk("t2_bubbles", 32'(bubbles), 0);
        chk("t2_crc16", (crc_hist.size() > 1) ? 32'(crc_hist[0]) : 32'hDEAD, 32'h1021);
        chk("t2_crc24", (crc_hist.size() > 1) ? 32'(crc_hist[1]) : 32'hDEAD, 32'h800063);

        // 3: CRC12, 40 zero bits
        crc_hist.delete();
        n0 = nout;
        send_frame(2'b01, 40, 0, 1'b0);
        chk("t3_busy_mid", 32'(busy), 1);
        drain("t3_drain");
        chk("t3_nout", 32'(nout - n0), 52);
        chk("t3_busy_end", 32'(busy), 0);
        chk("t3_crc", (crc_hist.size() > 0) ? 32'(crc_hist[$]) : 32'hDEAD, 0);

        // 4: random payloads, stalls, crc_sel toggling mid-frame
        stall_en = 1'b1;
        n0 = nout;
        for (int s = 0; s < 4; s++) send_frame(2'(s), 100, 2, 1'b1);
        drain("t4_drain");
        chk("t4_nout", 32'(nout - n0), 400 + 8 + 12 + 16 + 24);
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 5: reset during the CRC24 tail
        send_bit(1'b1, 1'b1, 2'b11, w);
        n0 = 0;
        while (rx.size() < 4 && n0 < 100) begin
            @(posedge clk);
            #1;
            n0++;
        end
        chk("t5_reach", 32'(rx.size() >= 4), 1);
        rst = 1'b1;
        sb.delete();
        rx.delete();
        rx_sel.delete();
        frame_new = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_in_ready", 32'(in_ready), 1);
        crc_hist.delete();
        send_frame(2'b00, 1, 1, 1'b0);
        drain("t5_drain");
        chk("t5_crc", (crc_hist.size() > 0) ? 32'(crc_hist[$]) : 32'hDEAD, 32'h9B);

        // 6: next bit held valid across the CRC16 tail
        send_frame(2'b10, 3, 2, 1'b0);
        send_bit(1'b1, 1'b1, 2'b00, w);
        chk("t6_wait", 32'(w), 16);
        drain("t6_drain");
        chk("t6_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
